alkmdseq: RTL and testbench
===========================

Name: alkmdseq

Overview:
- Multiply/divide step sequencer in the DC615 ALK (ALU control) chip on the DPM board.
- Sits directly downstream of the ALUSO/ALUF flag logic. It consumes the registered shift-out flag and the ALU carry, and produces per-step ALU function requests and the shift-direction controls that drive the ALUSO flag input mux.
- Implements the shift-and-add MUL loop and the non-restoring DIV loop, with a step counter, a final remainder-fix step, and a one-cycle completion pulse to microcode.

Parameters:
- STEPS, 32: number of iteration steps per MUL/DIV operation. Legal range 2..63.
- CNT_W, 6: width of the step counter. Must satisfy 2**CNT_W > STEPS.

Ports:
- qdclk_l  input  1  Clock. All state updates on the negative edge of qdclk_l, the same edge used by the ALUF flop.
- reset_h  input  1  Reset. Synchronous, active-high.
- mul_start_h  input  1  Begin MUL sequence. Sampled in IDLE only.
- div_start_h  input  1  Begin DIV sequence. Sampled in IDLE only.
- abort_h  input  1  Microcode abort/trap. Cancels any sequence in progress.
- aluso_flag_h  input  1  Registered ALU shift-out flag from the upstream ALUSO stage (current multiplier bit).
- alu_cout_h  input  1  ALU carry out of the current step (DIV: 1 = no borrow).
- alu_add_h  output  1  Request ALU A+B this cycle.
- alu_sub_h  output  1  Request ALU A-B this cycle.
- alu_pass_h  output  1  Request ALU pass-A this cycle.
- alpctl_shl_op_h  output  1  Shift-left step (DIV). Feeds the ALUSO mux.
- alpctl_shr_op_h  output  1  Shift-right step (MUL). Feeds the ALUSO mux.
- qbit_h  output  1  Quotient bit, registered, shifted into Q on the next step.
- step_cnt_h  output  CNT_W  Remaining-step counter.
- busy_h  output  1  High in MUL, DIV and DFIX states.
- done_h  output  1  One-cycle completion pulse.
- ovf_h  output  1  Sticky divide overflow.

Behaviour:
- States: IDLE, MUL, DIV, DFIX, DONE. Encoding is free.
- Reset (reset_h=1 at a clock edge), regardless of current state:
  - state=IDLE, step_cnt_h=0, qbit_h=0, ovf_h=0.
  - All outputs low; the output decode yields 0 in IDLE.
- IDLE:
  - mul_start_h=1: go to MUL, step_cnt_h=STEPS-1, ovf_h cleared.
  - Otherwise div_start_h=1: go to DIV, step_cnt_h=STEPS-1, qbit_h=1, ovf_h cleared.
  - Both starts asserted together: MUL wins.
  - Starts asserted in any state other than IDLE are ignored.
- MUL (one step per cycle):
  - alpctl_shr_op_h=1.
  - alu_add_h=aluso_flag_h and alu_pass_h=~aluso_flag_h. This decode is combinational on the input.
  - Each cycle step_cnt_h decrements. If step_cnt_h==0 in this cycle, go to DONE.
- DIV (non-restoring, one step per cycle):
  - alpctl_shl_op_h=1.
  - alu_sub_h=qbit_h and alu_add_h=~qbit_h.
  - At the clock edge: qbit_h<=alu_cout_h and step_cnt_h decrements.
  - On the first step (step_cnt_h==STEPS-1), alu_cout_h=1 sets ovf_h. The sequence still runs to completion.
  - If step_cnt_h==0 in this cycle, go to DFIX.
- DFIX:
  - qbit_h=0: alu_add_h=1 (remainder restore).
  - qbit_h=1: alu_pass_h=1.
  - No shift. Next state is DONE.
- DONE:
  - done_h=1 and busy_h=0 for exactly one cycle, then IDLE.
  - ovf_h, qbit_h and step_cnt_h (=0) hold until the next start or reset.
- Latency, counting from the edge that samples a start:
  - MUL: STEPS busy cycles, then the done_h cycle.
  - DIV: STEPS+1 busy cycles, then the done_h cycle.
- abort_h=1 at an edge in MUL, DIV, DFIX or DONE:
  - Next state IDLE, step_cnt_h=0, ovf_h cleared.
  - No done_h pulse (a done_h in progress is suppressed for the following cycle).
  - reset_h has priority over abort_h; abort_h has priority over start.
- Output invariants:
  - At most one of alu_add_h, alu_sub_h, alu_pass_h is high in any cycle.
  - alpctl_shl_op_h and alpctl_shr_op_h are never both high.
- Counter never wraps: it is loaded only from IDLE and stops at 0.

Test Plan:
- Reset: hold reset_h for 2 edges during DIV mid-sequence -> state IDLE, step_cnt_h=0, ovf_h=0, busy_h=0, all ALU requests 0 on the next cycle.
- MUL, STEPS=32, aluso_flag_h toggling 1,0,1,0,... -> 32 cycles with alpctl_shr_op_h=1, 16 alu_add_h and 16 alu_pass_h cycles, done_h exactly at cycle 33, step_cnt_h counts 31 down to 0.
- DIV with alu_cout_h=0 on every step -> first step alu_sub_h, then alu_add_h on every following step, ovf_h=0, DFIX issues alu_add_h, done_h at cycle 34.
- DIV with alu_cout_h=1 on the first step -> ovf_h=1 from cycle 2, held through done_h and IDLE, cleared by the next mul_start_h.
- Abort: abort_h at step 10 of MUL -> IDLE next cycle, no done_h. A simultaneous mul_start_h and div_start_h in IDLE -> MUL is entered.
- Busy start: div_start_h pulsed during MUL -> ignored; the MUL completes in 33 cycles.

Source files
------------

// File: rtl/alkmdseq_if.sv
// ============================================================================
// Module   : alkmdseq_if
// Brief    : Control/flag bundle between ALK microcode/ALU flags and the
//            MUL/DIV step sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alkmdseq_if #(
  parameter int CNT_W = 6
);
  logic             mul_start_h;
  logic             div_start_h;
  logic             abort_h;
  logic             aluso_flag_h;
  logic             alu_cout_h;
  logic             alu_add_h;
  logic             alu_sub_h;
  logic             alu_pass_h;
  logic             alpctl_shl_op_h;
  logic             alpctl_shr_op_h;
  logic             qbit_h;
  logic [CNT_W-1:0] step_cnt_h;
  logic             busy_h;
  logic             done_h;
  logic             ovf_h;

  modport master (
    output mul_start_h, div_start_h, abort_h, aluso_flag_h, alu_cout_h,
    input  alu_add_h, alu_sub_h, alu_pass_h, alpctl_shl_op_h, alpctl_shr_op_h,
    input  qbit_h, step_cnt_h, busy_h, done_h, ovf_h
  );

  modport slave (
    input  mul_start_h, div_start_h, abort_h, aluso_flag_h, alu_cout_h,
    output alu_add_h, alu_sub_h, alu_pass_h, alpctl_shl_op_h, alpctl_shr_op_h,
    output qbit_h, step_cnt_h, busy_h, done_h, ovf_h
  );
endinterface

`default_nettype wire

// File: rtl/alkmdseq.sv
// ============================================================================
// Module   : alkmdseq
// Brief    : DC615 ALK multiply/divide step sequencer (shift-and-add MUL,
//            non-restoring DIV with remainder fix, done pulse to microcode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alkmdseq #(
  parameter int STEPS = 32,
  parameter int CNT_W = 6
) (
  input  wire logic   qdclk_l,
  input  wire logic   reset_h,
  alkmdseq_if.slave   bus
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_MUL  = 3'd1;
  localparam logic [2:0] c_DIV  = 3'd2;
  localparam logic [2:0] c_DFIX = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] c_ZERO = '0;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qbit;
  logic             r_ovf;

  logic w_mul;
  logic w_div;
  logic w_fix;
  logic w_last;

  assign w_mul  = (r_state == c_MUL);
  assign w_div  = (r_state == c_DIV);
  assign w_fix  = (r_state == c_DFIX);
  assign w_last = (r_cnt == c_ZERO);

  // Same falling edge as the upstream ALUF flop.
  always_ff @(negedge qdclk_l) begin
    if (reset_h) begin
      r_state <= c_IDLE;
      r_cnt   <= c_ZERO;
      r_qbit  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.abort_h && (r_state != c_IDLE)) begin
      r_state <= c_IDLE;
      r_cnt   <= c_ZERO;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.mul_start_h) begin
            r_state <= c_MUL;
            r_cnt   <= c_LOAD;
            r_ovf   <= 1'b0;
          end else if (bus.div_start_h) begin
            r_state <= c_DIV;
            r_cnt   <= c_LOAD;
            r_qbit  <= 1'b1;
            r_ovf   <= 1'b0;
          end
        end
        c_MUL: begin
          if (w_last) r_state <= c_DONE;
          else        r_cnt   <= r_cnt - 1'b1;
        end
        c_DIV: begin
          r_qbit <= bus.alu_cout_h;
          // A non-borrow on the very first trial subtract means the quotient cannot fit.
          if ((r_cnt == c_LOAD) && bus.alu_cout_h) r_ovf <= 1'b1;
          if (w_last) r_state <= c_DFIX;
          else        r_cnt   <= r_cnt - 1'b1;
        end
        c_DFIX:  r_state <= c_DONE;
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.alu_add_h       = (w_mul & bus.aluso_flag_h) | ((w_div | w_fix) & ~r_qbit);
    bus.alu_sub_h       = w_div & r_qbit;
    bus.alu_pass_h      = (w_mul & ~bus.aluso_flag_h) | (w_fix & r_qbit);
    bus.alpctl_shl_op_h = w_div;
    bus.alpctl_shr_op_h = w_mul;
    bus.qbit_h          = r_qbit;
    bus.step_cnt_h      = r_cnt;
    bus.busy_h          = w_mul | w_div | w_fix;
    bus.done_h          = (r_state == c_DONE);
    bus.ovf_h           = r_ovf;
  end

endmodule

`default_nettype wire

// File: tb/tb_alkmdseq.sv
// ============================================================================
// Module   : tb_alkmdseq
// Brief    : Directed table plus hand sequences for the ALK MUL/DIV sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alkmdseq;

  localparam int STEPS = 32;
  localparam int CNT_W = 6;

  logic qdclk_l;
  logic reset_h;
  int   n_cmp;
  int   n_fail;
  int   n_add;
  int   n_pass;

  alkmdseq_if #(.CNT_W(CNT_W)) bus ();

  alkmdseq #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
    .qdclk_l (qdclk_l),
    .reset_h (reset_h),
    .bus     (bus)
  );

  initial qdclk_l = 1'b1;
  always #5 qdclk_l = ~qdclk_l;

  // {add, sub, pass, shl, shr, qbit, cnt[5:0], busy, done, ovf}
  function automatic logic [14:0] P(input logic add, sub, pass, shl, shr, q,
                                    input int cnt, input logic busy, done, ovf);
    logic [5:0] c;
    c = 6'(cnt);
    return {add, sub, pass, shl, shr, q, c, busy, done, ovf};
  endfunction

  // One clock: drive after the rising edge, sample before the falling edge.
  task automatic cyc(input logic mul, div, abort, flag, cout, rst,
                     input logic [14:0] exp, input string name);
    logic [14:0] act;
    @(posedge qdclk_l);
    #1;
    bus.mul_start_h  = mul;
    bus.div_start_h  = div;
    bus.abort_h      = abort;
    bus.aluso_flag_h = flag;
    bus.alu_cout_h   = cout;
    reset_h          = rst;
    #2;
    act = {bus.alu_add_h, bus.alu_sub_h, bus.alu_pass_h, bus.alpctl_shl_op_h,
           bus.alpctl_shr_op_h, bus.qbit_h, bus.step_cnt_h, bus.busy_h,
           bus.done_h, bus.ovf_h};
    n_add  += int'(bus.alu_add_h);
    n_pass += int'(bus.alu_pass_h);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b (add sub pass shl shr q cnt busy done ovf)",
               name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mul, div, abort, flag, cout, rst;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic f;
    n_cmp = 0; n_fail = 0; n_add = 0; n_pass = 0;
    bus.mul_start_h = 0; bus.div_start_h = 0; bus.abort_h = 0;
    bus.aluso_flag_h = 0; bus.alu_cout_h = 0; reset_h = 1;

    //           mul div abt flg cout rst   add sub pas shl shr q  cnt bsy dn ovf
    tbl[0]  = '{0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0,  0, 0, 0, 0)};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0,  0, 0, 0, 0)};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, P(1, 0, 0, 0, 1, 0, 31, 1, 0, 0)};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, P(0, 0, 1, 0, 1, 0, 30, 1, 0, 0)};
    tbl[4]  = '{0, 0, 1, 1, 0, 0, P(1, 0, 0, 0, 1, 0, 29, 1, 0, 0)};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0,  0, 0, 0, 0)};
    tbl[6]  = '{0, 1, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0,  0, 0, 0, 0)};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, P(0, 1, 0, 1, 0, 1, 31, 1, 0, 0)};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, P(0, 1, 0, 1, 0, 1, 30, 1, 0, 1)};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, P(1, 0, 0, 1, 0, 0, 29, 1, 0, 1)};
    tbl[10] = '{0, 0, 1, 0, 0, 0, P(0, 1, 0, 1, 0, 1, 28, 1, 0, 1)};
    tbl[11] = '{0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1,  0, 0, 0, 0)};
    tbl[12] = '{1, 0, 0, 0, 0, 1, P(0, 0, 0, 0, 0, 1,  0, 0, 0, 0)};
    tbl[13] = '{0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0,  0, 0, 0, 0)};

    @(negedge qdclk_l);
    @(negedge qdclk_l);

    for (int i = 0; i < 14; i++)
      cyc(tbl[i].mul, tbl[i].div, tbl[i].abort, tbl[i].flag, tbl[i].cout,
          tbl[i].rst, tbl[i].exp, $sformatf("tbl[%0d]", i));

    // Reset held two edges in the middle of a DIV.
    cyc(0, 1, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_start");
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 0, 0, 0, P(i != 0, i == 0, 0, 1, 0, i == 0, 31 - i, 1, 0, 0), "rst_div");
    cyc(0, 0, 0, 0, 0, 1, P(1, 0, 0, 1, 0, 0, 26, 1, 0, 0), "rst_edge1");
    cyc(0, 0, 0, 0, 0, 1, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_edge2");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_after");

    // Full MUL with toggling multiplier bit; a DIV start mid-run is ignored.
    cyc(1, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mul_start");
    n_add = 0; n_pass = 0;
    for (int i = 0; i < STEPS; i++) begin
      f = (i % 2 == 0);
      cyc(0, i == 5, 0, f, 0, 0, P(f, 0, ~f, 0, 1, 0, 31 - i, 1, 0, 0), $sformatf("mul_step%0d", i));
    end
    chk_int("mul_add_cycles", n_add, 16);
    chk_int("mul_pass_cycles", n_pass, 16);
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mul_done");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mul_idle");

    // DIV with borrow on every step: sub first, add afterwards, DFIX restores.
    cyc(0, 1, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "div0_start");
    for (int i = 0; i < STEPS; i++)
      cyc(0, 0, 0, 0, 0, 0, P(i != 0, i == 0, 0, 1, 0, i == 0, 31 - i, 1, 0, 0), $sformatf("div0_step%0d", i));
    cyc(0, 0, 0, 0, 0, 0, P(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), "div0_dfix");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "div0_done");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "div0_idle");

    // DIV overflow: no borrow on step 0 and on the last step (DFIX passes).
    cyc(0, 1, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "div1_start");
    for (int i = 0; i < STEPS; i++)
      cyc(0, 0, 0, 0, (i == 0) || (i == 31), 0,
          P(i > 1, i <= 1, 0, 1, 0, i <= 1, 31 - i, 1, 0, i != 0), $sformatf("div1_step%0d", i));
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 1, 0, 0, 1, 0, 1, 0, 1), "div1_dfix");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1, 0, 0, 1, 1), "div1_done");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "div1_idle");
    cyc(1, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1, 0, 0, 0, 1), "ovf_held_at_start");

    // MUL aborted at step 10: IDLE next cycle, ovf cleared, no done pulse.
    for (int i = 0; i <= 10; i++)
      cyc(0, 0, i == 10, 0, 0, 0, P(0, 0, 1, 0, 1, 1, 31 - i, 1, 0, 0), $sformatf("abt_step%0d", i));
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "abt_idle1");
    cyc(0, 0, 0, 0, 0, 0, P(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "abt_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
